// File: rtl/hs_dpath_pipe_ce_ctrl.sv
// Elastic valid/ready controller for a tapped-CE data shift register.
// Tracks per-stage valids, collapses bubbles and issues per-stage enables.
module hs_dpath_pipe_ce_ctrl #(
  parameter  int unsigned LATENCY = 1,
  localparam int unsigned CNT_W   = $clog2(64'(LATENCY) + 64'd1)
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LATENCY-1:0] ce,
  output logic [LATENCY-1:0] stage_valid,
  output logic [CNT_W-1:0]   occupancy,
  output logic               busy
);

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [LATENCY:0]   rdy;
  logic [LATENCY-1:0] src;
  logic [CNT_W-1:0]   occ_q;
  logic [CNT_W-1:0]   occ_d;
  logic               acc;
  logic               drn;

  // Ready ripples back from the output; an empty stage is always ready.
  always_comb begin
    rdy = '0;
    rdy[LATENCY] = out_ready;
    for (int i = int'(LATENCY) - 1; i >= 0; i--) begin
      rdy[i] = !vld_q[i] || rdy[i+1];
    end
  end

  always_comb begin
    src = '0;
    src[0] = in_valid;
    for (int i = 1; i < int'(LATENCY); i++) begin
      src[i] = vld_q[i-1];
    end
  end

  always_comb begin
    ce    = '0;
    vld_d = vld_q;
    for (int i = 0; i < int'(LATENCY); i++) begin
      ce[i] = rdy[i] && src[i] && !flush;
      if (flush) begin
        vld_d[i] = 1'b0;
      end else if (rdy[i]) begin
        vld_d[i] = src[i];
      end
    end
  end

  assign in_ready    = rdy[0] && !flush;
  assign out_valid   = vld_q[LATENCY-1];
  assign stage_valid = vld_q;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + CNT_W'(acc) - CNT_W'(drn);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign busy      = (occ_q != '0);

  a_occ_popcount: assert property (
    @(posedge clk) disable iff (areset)
    occ_q == CNT_W'($countones(vld_q))
  );

  a_occ_bound: assert property (
    @(posedge clk) disable iff (areset)
    64'(occ_q) <= 64'(LATENCY)
  );

endmodule

// File: tb/tb_hs_dpath_pipe_ce_ctrl.sv
// Scoreboard bench for hs_dpath_pipe_ce_ctrl with a slot-based pipe model
// and a CE-driven data shift register carrying beat tags.
module tb_hs_dpath_pipe_ce_ctrl;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         areset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [L-1:0] ce;
  logic [L-1:0] stage_valid;
  logic [2:0]   occupancy;
  logic         busy;
  logic [7:0]   in_data;
  logic [7:0]   sr [L];

  int slot [L];
  int sbq [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hs_dpath_pipe_ce_ctrl #(.LATENCY(L)) dut (
    .clk         (clk),
    .areset      (areset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ce          (ce),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .busy        (busy)
  );

  // The data path the controller steers.
  always @(posedge clk) begin
    if (ce[0]) sr[0] <= in_data;
    for (int i = 1; i < L; i++) begin
      if (ce[i]) sr[i] <= sr[i-1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!areset && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got %0h expected no beat", sr[L-1]);
        end else begin
          chk("out_data", {24'd0, sr[L-1]}, sbq.pop_front());
        end
      end
    end
  end

  // Pipe as slots holding beat tags (-1 empty); items slide toward the
  // output whenever the slot ahead is free after the output end moved.
  task automatic do_cycle(input bit iv, input bit ordy, input bit fl);
    bit [L-1:0] ce_e;
    bit [L-1:0] sv_e;
    bit inr_e;
    bit acc;
    bit drn;
    int s [L];
    int occ;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = 8'($urandom_range(0, 255));
    #2;
    s = slot;
    ce_e = '0;
    sv_e = '0;
    occ = 0;
    for (int i = 0; i < L; i++) begin
      if (s[i] >= 0) begin
        sv_e[i] = 1'b1;
        occ++;
      end
    end
    drn = (s[L-1] >= 0) && ordy;
    if (drn) s[L-1] = -1;
    for (int i = L - 2; i >= 0; i--) begin
      if (s[i] >= 0 && s[i+1] < 0) begin
        s[i+1] = s[i];
        s[i] = -1;
        ce_e[i+1] = 1'b1;
      end
    end
    inr_e = (s[0] < 0) && !fl;
    acc = iv && inr_e;
    if (acc) begin
      s[0] = int'(in_data);
      ce_e[0] = 1'b1;
    end
    if (fl) begin
      ce_e = '0;
      for (int i = 0; i < L; i++) s[i] = -1;
    end
    chk("stage_valid", 32'(stage_valid), 32'(sv_e));
    chk("occupancy", 32'(occupancy), occ);
    chk("out_valid", 32'(out_valid), 32'(sv_e[L-1]));
    chk("busy", 32'(busy), 32'(occ != 0));
    chk("in_ready", 32'(in_ready), 32'(inr_e));
    chk("ce", 32'(ce), 32'(ce_e));
    if (acc) sbq.push_back(int'(in_data));
    if (fl) begin
      if (drn) begin
        while (sbq.size() > 1) void'(sbq.pop_back());
      end else begin
        sbq.delete();
      end
    end
    @(posedge clk);
    slot = s;
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1 areset = 1'b1;
    #1;
    chk("rst_stage_valid", 32'(stage_valid), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ce", 32'(ce), 0);
    areset = 1'b0;
    for (int i = 0; i < L; i++) slot[i] = -1;
    sbq.delete();
    @(posedge clk);
  endtask

  initial begin
    areset    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    for (int i = 0; i < L; i++) slot[i] = -1;
    #12;
    chk("init_stage_valid", 32'(stage_valid), 0);
    chk("init_occupancy", 32'(occupancy), 0);
    chk("init_in_ready", 32'(in_ready), 1);
    chk("init_ce", 32'(ce), 0);
    chk("init_out_valid", 32'(out_valid), 0);
    chk("init_busy", 32'(busy), 0);
    @(negedge clk);
    areset = 1'b0;

    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0);

    do_cycle(1'b0, 1'b1, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0);
    #1 chk("bubble_pack", 32'(stage_valid), 32'h0000_000c);

    do_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      do_cycle(($urandom % 4) != 0, ($urandom % 3) != 0,
               ($urandom % 40) == 0);
    end

    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 1'b0);
    #4;
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
